// File: rtl/logic_vector_sequencer_if.sv
// Bundle between the vector sequencer and the logic block under test.
// The master side is the sequencer: it drives a..d and reports status; the slave side drives start and y.
interface logic_vector_sequencer_if;
   logic        start;
   logic        a;
   logic        b;
   logic        c;
   logic        d;
   logic        y;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [4:0]  mismatch_cnt;
   logic        pass;

   modport master (
      input  start, y,
      output a, b, c, d, busy, done, result, mismatch_cnt, pass
   );

   modport slave (
      output start, y,
      input  a, b, c, d, busy, done, result, mismatch_cnt, pass
   );
endinterface

// File: rtl/logic_vector_sequencer.sv
// Sweeps vectors 0..LAST_VEC onto {a,b,c,d}, samples y after each dwell, and scores the result against EXPECTED.
// Optional macro SEQ_STOP_ON_FAIL_EN: abort the sweep on the first mismatching sample.
module logic_vector_sequencer #(
   parameter int unsigned DWELL    = 8,
   parameter int unsigned LAST_VEC = 15,
   parameter logic [15:0] EXPECTED = 16'h0000
) (
   input logic                      clk,
   input logic                      rst_n,
   logic_vector_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
   localparam logic [3:0] LAST_IDX   = 4'(LAST_VEC);

   state_t      state_r,       state_nxt_s;
   logic [3:0]  vec_r,         vec_nxt_s;
   logic [7:0]  dwell_cnt_r,   dwell_cnt_nxt_s;
   logic [3:0]  drive_r,       drive_nxt_s;
   logic        busy_r,        busy_nxt_s;
   logic        done_r,        done_nxt_s;
   logic        pass_r,        pass_nxt_s;
   logic [15:0] result_r,      result_nxt_s;
   logic [4:0]  mismatch_r,    mismatch_nxt_s;
   logic        miss_s;
   logic [4:0]  mismatch_inc_s;
   logic        last_sample_s;

   function automatic logic bit_miss(input logic [15:0] exp_tt, input logic [3:0] idx, input logic obs);
      return (obs != exp_tt[idx]);
   endfunction

   // Next-state and next-output logic for the sweep FSM.
   always_comb begin
      state_nxt_s     = state_r;
      vec_nxt_s       = vec_r;
      dwell_cnt_nxt_s = dwell_cnt_r;
      drive_nxt_s     = drive_r;
      busy_nxt_s      = busy_r;
      done_nxt_s      = 1'b0;
      pass_nxt_s      = pass_r;
      result_nxt_s    = result_r;
      mismatch_nxt_s  = mismatch_r;
      miss_s          = bit_miss(EXPECTED, vec_r, bus.y);
      mismatch_inc_s  = mismatch_r + (miss_s ? 5'd1 : 5'd0);
`ifdef SEQ_STOP_ON_FAIL_EN
      last_sample_s   = (vec_r == LAST_IDX) || miss_s;
`else
      last_sample_s   = (vec_r == LAST_IDX);
`endif
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s     = RUN;
               vec_nxt_s       = 4'd0;
               dwell_cnt_nxt_s = 8'd0;
               drive_nxt_s     = 4'd0;
               busy_nxt_s      = 1'b1;
               pass_nxt_s      = 1'b0;
               result_nxt_s    = 16'h0000;
               mismatch_nxt_s  = 5'd0;
            end else begin
               drive_nxt_s = 4'd0;
               busy_nxt_s  = 1'b0;
            end
         end
         RUN: begin
            if (dwell_cnt_r == DWELL_LAST) begin
               dwell_cnt_nxt_s      = 8'd0;
               result_nxt_s[vec_r]  = bus.y;
               mismatch_nxt_s       = mismatch_inc_s;
               if (last_sample_s) begin
                  state_nxt_s = DONE;
                  drive_nxt_s = 4'd0;
                  busy_nxt_s  = 1'b0;
                  done_nxt_s  = 1'b1;
                  pass_nxt_s  = (mismatch_inc_s == 5'd0);
               end else begin
                  vec_nxt_s   = vec_r + 4'd1;
                  drive_nxt_s = vec_r + 4'd1;
               end
            end else begin
               dwell_cnt_nxt_s = dwell_cnt_r + 8'd1;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
            drive_nxt_s = 4'd0;
            busy_nxt_s  = 1'b0;
         end
         default: begin
            state_nxt_s = IDLE;
            drive_nxt_s = 4'd0;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears any partial sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         vec_r       <= 4'd0;
         dwell_cnt_r <= 8'd0;
         drive_r     <= 4'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         result_r    <= 16'h0000;
         mismatch_r  <= 5'd0;
      end else begin
         state_r     <= state_nxt_s;
         vec_r       <= vec_nxt_s;
         dwell_cnt_r <= dwell_cnt_nxt_s;
         drive_r     <= drive_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         pass_r      <= pass_nxt_s;
         result_r    <= result_nxt_s;
         mismatch_r  <= mismatch_nxt_s;
      end
   end

   assign bus.a            = drive_r[3];
   assign bus.b            = drive_r[2];
   assign bus.c            = drive_r[1];
   assign bus.d            = drive_r[0];
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.pass         = pass_r;
   assign bus.result       = result_r;
   assign bus.mismatch_cnt = mismatch_r;

endmodule

// File: doc/logic_vector_sequencer.md
Name: logic_vector_sequencer

Overview:
- Upstream stimulus and downstream capture stage for the 4-input combinational logic block (inputs a,b,c,d; output y).
- On start, walks the input vectors 0..LAST_VEC on {a,b,c,d} and holds each for DWELL cycles.
- Samples y at the end of each dwell, builds a captured truth table, and compares it bit-by-bit against EXPECTED.
- Reports the mismatch count and pass/fail, so the logic block gets a self-checking, clocked harness in silicon and simulation.

Parameters:
- DWELL, 8: cycles each vector is held before y is sampled; legal range 1..255.
- LAST_VEC, 15: last vector index driven; legal range 0..15.
- EXPECTED, 16'h0000: expected y per vector; bit i = expected y for vector i.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE
- a  output  1  vector bit 3 (MSB) to logic block
- b  output  1  vector bit 2
- c  output  1  vector bit 1
- d  output  1  vector bit 0 (LSB)
- y  input  1  logic block output
- busy  output  1  high while sweep in progress
- done  output  1  one-cycle pulse at end of sweep
- result  output  16  captured y; bit i = y sampled for vector i
- mismatch_cnt  output  5  number of bits where result differs from EXPECTED (0..16)
- pass  output  1  high when the last completed sweep had mismatch_cnt==0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n low, any time including mid-sweep): state=IDLE; a,b,c,d,busy,done,pass=0; result=16'h0; mismatch_cnt=0; vec=0; dwell counter=0. No partial results survive reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - {a,b,c,d}=0, busy=0.
  - start=1 at edge E0 → RUN, vec=0, dwell counter=0, result=0, mismatch_cnt=0, pass=0.
- RUN:
  - {a,b,c,d}=vec[3:0] (registered), busy=1.
  - Dwell counter increments each cycle.
  - At the edge where counter==DWELL-1:
    - result[vec] <= y.
    - If y != EXPECTED[vec], mismatch_cnt increments.
    - Counter resets to 0.
    - If vec==LAST_VEC → DONE; else vec increments.
- Sample timing: y for vector k is sampled at edge E0+(k+1)*DWELL. Vector k is stable on a..d for exactly DWELL cycles before that edge.
- DONE (one cycle):
  - done=1, busy=0, {a,b,c,d}=0.
  - pass=(mismatch_cnt==0) after the final increment.
  - Next edge → IDLE.
  - done is high during the cycle following edge E0+(LAST_VEC+1)*DWELL.
- start while RUN or DONE: ignored, no restart, no effect on counters. start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- result bits above LAST_VEC stay 0 and are not compared. mismatch_cnt cannot wrap (max 16 fits in 5 bits).
- result, mismatch_cnt, and pass hold their values in IDLE until the next accepted start.
- DWELL=1: each vector is held one cycle; y is sampled on the edge that ends that cycle.

Optional Feature:
- Macro: SEQ_STOP_ON_FAIL_EN.
- Defined: on the first sample where y != EXPECTED[vec], mismatch_cnt becomes 1, result[vec] is captured, and the FSM goes directly to DONE. Remaining result bits stay 0 and pass=0. Early done occurs at edge E0+(k+1)*DWELL for failing vector k.
- Undefined: the full sweep always runs to LAST_VEC regardless of mismatches.

Test Plan:
- Model y=c^d; DWELL=8, LAST_VEC=15, EXPECTED=16'h6666; pulse start → a..d step 0000..1111 every 8 cycles; done pulses 128 cycles after start edge; result=16'h6666; mismatch_cnt=0; pass=1.
- y tied 0, EXPECTED=16'h6666 → result=16'h0000, mismatch_cnt=8, pass=0, done at cycle 128.
- DWELL=1, LAST_VEC=3, y=d, EXPECTED=16'h000A → vectors 0,1,2,3 on consecutive cycles; done 4 cycles after start; result=16'h000A; pass=1; result[15:4]=0.
- Start pulses at cycles 10 and 50 during a sweep → ignored; done still exactly 128 cycles after the original start; only one done pulse.
- rst_n low while vec=5 → all outputs 0 immediately (asynchronous); after release, start → sweep restarts at vector 0 and completes normally.
- With SEQ_STOP_ON_FAIL_EN: y tied 0, EXPECTED=16'h6666, DWELL=8 → abort at vector 1; done 16 cycles after start; mismatch_cnt=1; result=16'h0000; pass=0.
